stack16: RTL

STACK16 -- requirements
Module: stack16

---
 rtl/stack16.sv | 114 +++++++++++
 1 files changed

// File: rtl/stack16.sv
// stack16: registered LIFO of DEPTH words of WIDTH bits.
// Top-of-stack is held in a dedicated output register so that o_out never
// depends combinationally on the inputs. The storage array only holds the
// entries below and including the top; nothing past o_count is ever read out.
module stack16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_in,
  output logic [WIDTH-1:0]           o_out,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_do_repl;
  logic             w_ovf;
  logic             w_unf;
  logic             w_mem_we;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [AW:0]      w_cnt_m1;
  logic [AW:0]      w_cnt_m2;
  logic [WIDTH-1:0] w_pop_val;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);
  assign w_cnt_m1 = r_count - (AW+1)'(1);
  assign w_cnt_m2 = r_count - (AW+1)'(2);

  // Decode the requested operation; push+pop on an empty stack is a plain push.
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    w_do_repl = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (!i_clear) begin
      if (i_push && i_pop) begin
        if (w_empty) w_do_push = 1'b1;
        else         w_do_repl = 1'b1;
      end else if (i_push) begin
        if (w_full) w_ovf     = 1'b1;
        else        w_do_push = 1'b1;
      end else if (i_pop) begin
        if (w_empty) w_unf    = 1'b1;
        else         w_do_pop = 1'b1;
      end
    end
  end

  // Storage addressing: a push writes the slot at count, a replace overwrites
  // the current top at count-1; a pop reads the new top at count-2.
  always_comb begin
    w_mem_we  = w_do_push | w_do_repl;
    w_wr_idx  = w_do_repl ? w_cnt_m1[AW-1:0] : r_count[AW-1:0];
    w_rd_idx  = w_cnt_m2[AW-1:0];
    w_pop_val = (r_count == (AW+1)'(1)) ? '0 : r_mem[w_rd_idx];
  end

  // Storage array write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= i_in;
  end

  // Count, top-of-stack register and sticky error flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_count <= r_count + (AW+1)'(1);
        r_out   <= i_in;
      end else if (w_do_repl) begin
        r_out   <= i_in;
      end else if (w_do_pop) begin
        r_count <= w_cnt_m1;
        r_out   <= w_pop_val;
      end
      if (w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  assign o_out   = r_out;
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_err   = r_err;

endmodule
